// File: rtl/ring_keypad_scanner_pkg.sv
// Shared constants, FSM state type and one-hot helpers for the ring keypad scanner.
package ring_keypad_scanner_pkg;

  localparam int unsigned KEY_W    = 4;
  localparam int unsigned NUM_COLS = 4;
  localparam int unsigned NUM_ROWS = 4;
  localparam int unsigned COL_W    = 2;
  localparam int unsigned SNAP_W   = NUM_COLS * NUM_ROWS;

  typedef enum logic [1:0] {IDLE, DEBOUNCE, HELD} scan_state_e;

  // True when exactly one bit of v is set.
  function automatic logic is_onehot(input logic [SNAP_W-1:0] v);
    return (v != '0) && ((v & (v - SNAP_W'(1))) == '0);
  endfunction

  // Index of the set bit; only meaningful when v is one-hot.
  function automatic logic [KEY_W-1:0] onehot_to_idx(input logic [SNAP_W-1:0] v);
    logic [KEY_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < int'(SNAP_W); i++) begin
      if (v[i]) idx = KEY_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_snapshot_assembler.sv
// Collects one row sample per ring phase into a 16-bit snapshot per full rotation.
module keypad_snapshot_assembler
  import ring_keypad_scanner_pkg::*;
(
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] ring,
  input  logic [NUM_ROWS-1:0] row,
  output logic [SNAP_W-1:0]   snapshot,
  output logic                snap_done,
  output logic                ring_bad
);

  logic [SNAP_W-1:0]   scan_acc, acc_next;
  logic [NUM_COLS-1:0] seen, seen_next;
  logic [KEY_W-1:0]    col_idx;
  logic [COL_W-1:0]    col;
  logic                ring_ok;

  assign ring_ok  = is_onehot(SNAP_W'(ring));
  assign ring_bad = ~ring_ok;
  assign col_idx  = onehot_to_idx(SNAP_W'(ring));
  assign col      = col_idx[COL_W-1:0];

  // Next accumulator/seen state for this cycle's column sample.
  always_comb begin
    acc_next  = scan_acc;
    seen_next = seen;
    if (!ring_ok) begin
      acc_next  = '0;
      seen_next = '0;
    end else if (seen[col]) begin
      // Column revisited before the rotation completed: restart from this column.
      acc_next                          = '0;
      acc_next[col*NUM_ROWS +: NUM_ROWS] = row;
      seen_next                         = '0;
      seen_next[col]                    = 1'b1;
    end else begin
      acc_next[col*NUM_ROWS +: NUM_ROWS] = row;
      seen_next[col]                    = 1'b1;
    end
  end

  // Accumulator registers; publish the snapshot once every column has been seen.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      scan_acc  <= '0;
      seen      <= '0;
      snapshot  <= '0;
      snap_done <= 1'b0;
    end else begin
      snap_done <= 1'b0;
      if (seen_next == '1) begin
        snap_done <= 1'b1;
        snapshot  <= acc_next;
        scan_acc  <= '0;
        seen      <= '0;
      end else begin
        scan_acc <= acc_next;
        seen     <= seen_next;
      end
    end
  end

endmodule

// File: rtl/ring_keypad_scanner.sv
// Keypad scanner: debounces ring-strobed snapshots and emits one key code per press.
module ring_keypad_scanner
  import ring_keypad_scanner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned CNT_W          = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_COLS-1:0] ring,
  input  logic [NUM_ROWS-1:0] row,
  input  logic                key_ready,
  input  logic                clear_err,
  output logic [KEY_W-1:0]    key_code,
  output logic                key_valid,
  output logic                multi_err,
  output logic                ovf_err,
  output logic                ring_err
);

  localparam logic [CNT_W-1:0] DEB_N = CNT_W'(DEBOUNCE_SCANS);

  logic [SNAP_W-1:0] snapshot;
  logic              snap_done;
  logic              ring_bad;

  scan_state_e       state_q, state_d;
  logic [SNAP_W-1:0] cand_q, cand_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [CNT_W-1:0]  rel_cnt_q, rel_cnt_d;
  logic              accept, emit, multi_set, ovf_set;
  logic [KEY_W-1:0]  key_code_d;
  logic              key_valid_d, multi_err_d, ovf_err_d, ring_err_d;

  keypad_snapshot_assembler u_assembler (
    .clk       (clk),
    .reset     (reset),
    .ring      (ring),
    .row       (row),
    .snapshot  (snapshot),
    .snap_done (snap_done),
    .ring_bad  (ring_bad)
  );

  // Debounce FSM: advances only on completed snapshots.
  always_comb begin
    state_d   = state_q;
    cand_d    = cand_q;
    cnt_d     = cnt_q;
    rel_cnt_d = rel_cnt_q;
    accept    = 1'b0;
    if (snap_done) begin
      case (state_q)
        IDLE: begin
          if (snapshot != '0) begin
            cand_d  = snapshot;
            cnt_d   = CNT_W'(1);
            state_d = DEBOUNCE;
          end
        end
        DEBOUNCE: begin
          if (snapshot == '0) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else if (snapshot == cand_q) begin
            cnt_d = cnt_q + CNT_W'(1);
          end else begin
            cand_d = snapshot;
            cnt_d  = CNT_W'(1);
          end
        end
        HELD: begin
          if (snapshot == '0) begin
            rel_cnt_d = rel_cnt_q + CNT_W'(1);
            if (rel_cnt_d == DEB_N) begin
              rel_cnt_d = '0;
              state_d   = IDLE;
            end
          end else begin
            rel_cnt_d = '0;
          end
        end
        default: state_d = IDLE;
      endcase
      // Shared acceptance, so a single-scan debounce accepts straight out of IDLE.
      if (state_d == DEBOUNCE && cnt_d == DEB_N) begin
        accept    = 1'b1;
        cnt_d     = '0;
        rel_cnt_d = '0;
        state_d   = HELD;
      end
    end
  end

  assign emit      = accept & is_onehot(cand_d);
  assign multi_set = accept & ~is_onehot(cand_d);

  // Output register and sticky flags; a full, unconsumed register drops the new event.
  always_comb begin
    key_valid_d = key_valid & ~key_ready;
    key_code_d  = key_code;
    ovf_set     = 1'b0;
    if (emit) begin
      if (key_valid && !key_ready) begin
        ovf_set = 1'b1;
      end else begin
        key_code_d  = onehot_to_idx(cand_d);
        key_valid_d = 1'b1;
      end
    end
    multi_err_d = (multi_err & ~clear_err) | multi_set;
    ovf_err_d   = (ovf_err & ~clear_err) | ovf_set;
    ring_err_d  = (ring_err & ~clear_err) | ring_bad;
  end

  // State and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      cand_q    <= '0;
      cnt_q     <= '0;
      rel_cnt_q <= '0;
      key_code  <= '0;
      key_valid <= 1'b0;
      multi_err <= 1'b0;
      ovf_err   <= 1'b0;
      ring_err  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cand_q    <= cand_d;
      cnt_q     <= cnt_d;
      rel_cnt_q <= rel_cnt_d;
      key_code  <= key_code_d;
      key_valid <= key_valid_d;
      multi_err <= multi_err_d;
      ovf_err   <= ovf_err_d;
      ring_err  <= ring_err_d;
    end
  end

endmodule
